// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg : shared types and constants for the pipeline controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } arb_state_e;

   localparam int unsigned PERF_CNT_W = 32;

endpackage

`default_nettype wire

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb : IF/MEM arbiter for the shared memory port, with fetch-drop flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arb
   import pipe_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       if_req,
   input  logic       mem_req,
   input  logic       port_done,
   input  logic       br_flush_i,
   output logic       gnt_if_o,
   output logic       gnt_mem_o,
   output logic       if_drop_o,
   output arb_state_e state_o
);

   arb_state_e state_q, state_d;
   logic       drop_q, drop_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (mem_req)     state_d = MEM_BUSY;
            else if (if_req) state_d = IF_BUSY;
         end
         IF_BUSY, MEM_BUSY: begin
            if (port_done) begin
               if (mem_req)
                  state_d = MEM_BUSY;
               else if (if_req && !((state_q == MEM_BUSY) && drop_q))
                  state_d = IF_BUSY;
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A redirect while a fetch is still in flight marks its data as stale.
   always_comb begin
      drop_d = drop_q;
      if (state_q == IF_BUSY) begin
         if (port_done)       drop_d = 1'b0;
         else if (br_flush_i) drop_d = 1'b1;
      end
   end

   assign gnt_if_o  = (state_q == IF_BUSY);
   assign gnt_mem_o = (state_q == MEM_BUSY);
   assign if_drop_o = (drop_q | br_flush_i) & port_done & (state_q == IF_BUSY);
   assign state_o   = state_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl : per-stage stall/flush sequencing for the five-stage core.
// PIPE_CTRL_PERF_EN enables the stall/flush performance counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic                  mem_req,
   input  logic                  port_done,
   input  logic                  ld_use,
   input  logic                  br_taken,
   output logic                  gnt_if,
   output logic                  gnt_mem,
   output logic                  if_drop,
   output logic                  stl_if,
   output logic                  stl_id,
   output logic                  stl_ex,
   output logic                  stl_mm,
   output logic                  fl_id,
   output logic                  fl_ex,
   output logic                  fl_wb,
   output logic [PERF_CNT_W-1:0] perf_stall,
   output logic [PERF_CNT_W-1:0] perf_flush
);

   arb_state_e state;
   logic       mem_stall;
   logic       fetch_wait;
   logic       br_flush;

   assign mem_stall  = ((state == MEM_BUSY) && !port_done) ||
                       (mem_req && (state != MEM_BUSY));
   assign fetch_wait = ((state == IF_BUSY) && !port_done) ||
                       ((state == IDLE) && if_req);
   // A branch behind a MEM stall stays asserted and is applied once the stall releases.
   assign br_flush   = br_taken && !mem_stall;

   mem_port_arb u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .mem_req    (mem_req),
      .port_done  (port_done),
      .br_flush_i (br_flush),
      .gnt_if_o   (gnt_if),
      .gnt_mem_o  (gnt_mem),
      .if_drop_o  (if_drop),
      .state_o    (state)
   );

   always_comb begin
      stl_if = 1'b0;
      stl_id = 1'b0;
      stl_ex = 1'b0;
      stl_mm = 1'b0;
      fl_id  = 1'b0;
      fl_ex  = 1'b0;
      fl_wb  = 1'b0;
      if (mem_stall) begin
         stl_if = 1'b1;
         stl_id = 1'b1;
         stl_ex = 1'b1;
         stl_mm = 1'b1;
         fl_wb  = 1'b1;
      end else if (br_taken) begin
         fl_id = 1'b1;
         fl_ex = 1'b1;
      end else if (ld_use) begin
         stl_if = 1'b1;
         stl_id = 1'b1;
         fl_ex  = 1'b1;
      end else if (fetch_wait) begin
         stl_if = 1'b1;
         fl_id  = 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   assign stall_cnt_d = stl_if   ? stall_cnt_q + PERF_CNT_W'(1) : stall_cnt_q;
   assign flush_cnt_d = br_flush ? flush_cnt_q + PERF_CNT_W'(1) : flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall = stall_cnt_q;
   assign perf_flush = flush_cnt_q;
`else
   assign perf_stall = '0;
   assign perf_flush = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage RISC-V core. It arbitrates the single shared memory port between instruction fetch (IF) and load/store (MEM). From arbitration state, load-use hazards and taken branches, it generates the per-stage stall and flush controls consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. A flushed register loads the all-zero bubble, so its type field is 0.

## Interface

- No parameters.
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch wants the memory port.
- mem_req  in  1  MEM stage holds a pending load/store.
- port_done  in  1  single-cycle pulse: the granted transaction completes this cycle.
- ld_use  in  1  ID detects a load-use hazard against EX (combinational from ID).
- br_taken  in  1  EX resolved a taken branch or jump.
- gnt_if  out  1  port granted to IF (registered).
- gnt_mem  out  1  port granted to MEM (registered).
- if_drop  out  1  discard the fetch data returned with this port_done.
- stl_if  out  1  hold pc_reg.
- stl_id  out  1  hold if_id.
- stl_ex  out  1  hold id_ex.
- stl_mm  out  1  hold ex_mem.
- fl_id  out  1  load a bubble into if_id.
- fl_ex  out  1  load a bubble into id_ex.
- fl_wb  out  1  load a bubble into mem_wb.
- perf_stall  out  32  stall-cycle count. Active with PIPE_CTRL_PERF_EN; otherwise 0.
- perf_flush  out  32  branch-flush count. Active with PIPE_CTRL_PERF_EN; otherwise 0.

## Operation

**Arbitration FSM**
- States: IDLE, IF_BUSY, MEM_BUSY.
- IDLE → MEM_BUSY if mem_req. Else IDLE → IF_BUSY if if_req. MEM has priority because it holds the older instruction.
- In a BUSY state with port_done:
  - go to MEM_BUSY if mem_req;
  - else go to IF_BUSY if if_req (and not leaving MEM_BUSY with a branch pending drop);
  - else go to IDLE.
- This allows back-to-back grants.
- No preemption: if mem_req rises during IF_BUSY, the fetch completes first.
- gnt_if is 1 exactly in IF_BUSY. gnt_mem is 1 exactly in MEM_BUSY.

**Stall and flush priority** (highest first, combinational from state and inputs):
1. **MEM stall.** Condition: MEM_BUSY without port_done, or mem_req pending while the port is not granted to MEM. Response: stl_if, stl_id, stl_ex and stl_mm all 1, fl_wb=1. br_taken and ld_use are ignored; both stay asserted because their stages are frozen.
2. **Branch.** Condition: br_taken. Response: fl_id=1, fl_ex=1, no stalls. If the state is IF_BUSY without port_done, the drop flag is set.
3. **Load-use.** Condition: ld_use. Response: stl_if=1, stl_id=1, fl_ex=1 for one cycle.
4. **Fetch wait.** Condition: IF_BUSY without port_done, or IDLE with if_req. Response: stl_if=1, fl_id=1.

**Drop flag**
- if_drop = drop flag AND port_done AND gnt_if.
- The flag clears on that port_done.
- A branch coinciding with the IF port_done asserts if_drop combinationally in that same cycle.

## Timing

- Reset values:
  - state = IDLE;
  - gnt_if = gnt_mem = 0;
  - drop flag = 0;
  - perf counters = 0.
- During reset, all combinational outputs evaluate with reset state and are low unless inputs demand otherwise.
- Grant latency: a request sampled at edge N gives a grant visible in cycle N+1. The grant is held through the port_done cycle inclusive.
- Asynchronous reset mid-transaction aborts the grant immediately. The memory controller also resets, so no done is expected.
- port_done in IDLE is ignored.
- Counters wrap modulo 2^32:
  - perf_stall increments in any cycle with stl_if=1;
  - perf_flush increments in any cycle with fl_ex=1 caused by br_taken.

## Configuration

- PIPE_CTRL_PERF_EN defined: both 32-bit counters are implemented.
- PIPE_CTRL_PERF_EN undefined: perf_stall and perf_flush are tied to 0 and no counter flops exist. Ports remain present.

## Structure

- pipe_ctrl_pkg holds:
  - the arbitration state enum (IDLE=2'd0, IF_BUSY=2'd1, MEM_BUSY=2'd2);
  - the counter width constant (32).
- Sub-module mem_port_arb: the FSM, grants and drop flag.
- pipe_ctrl: the priority stall/flush logic and the perf counters.

## Test plan

- **Fetch grant.** Stimulus: reset, then if_req=1, with port_done 3 cycles after the grant. Required response: gnt_if=1 for 3 cycles; stl_if=1 and fl_id=1 until the done cycle; state then IDLE.
- **Request collision.** Stimulus: if_req=1 and mem_req=1 together in IDLE. Required response: gnt_mem first with all four stalls and fl_wb=1; on port_done, immediate gnt_if the next cycle.
- **Branch during fetch.** Stimulus: br_taken during IF_BUSY 2 cycles before port_done. Required response: fl_id=1 and fl_ex=1 that cycle; if_drop=1 in the done cycle; drop flag 0 afterwards.
- **Load-use.** Stimulus: ld_use=1 for one cycle with the port idle. Required response: stl_if=1, stl_id=1, fl_ex=1; stl_ex=0 and stl_mm=0.
- **Branch held behind MEM stall.** Stimulus: br_taken together with MEM_BUSY. Required response: no flush until the port_done cycle; flush is applied when the stall releases; perf_flush increments once.
- **Mid-transaction reset.** Stimulus: rst_n low in MEM_BUSY. Required response: gnt_mem=0 immediately; counters 0.
